multicycle_ripple_adder: RTL and testbench
==========================================

Name: multicycle_ripple_adder

Overview:
Parametrised, sequential successor to the fixed 4-bit ripple carry adder. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, reusing one CHUNK-wide ripple slice across WIDTH/CHUNK cycles. A start/ready/done handshake frames each operation. It is the shared arithmetic block for wide datapaths where a full-width ripple chain would not meet timing.

Parameters:
WIDTH, 16, operand and sum width in bits
CHUNK, 4, bits added per cycle; WIDTH must be an integer multiple of CHUNK (1 <= CHUNK <= WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; accepted only when ready=1
a  input  WIDTH  operand A, sampled on the accepting edge
b  input  WIDTH  operand B, sampled on the accepting edge
c_zero  input  1  carry-in, sampled on the accepting edge
ready  output  1  block idle and able to accept start
done  output  1  one-cycle pulse: sum/c_out/ovf just updated
sum  output  WIDTH  registered result
c_out  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clocking: one clock, clk. Reset: rst, asynchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, sum=0, c_out=0, ovf=0, chunk index=0, internal accumulators=0.
- Reset mid-operation: the operation is abandoned. Outputs return to reset values immediately. The first start is accepted on the first rising edge with rst=0.
- Let N = WIDTH/CHUNK.
- FSM states: IDLE, ADD, DONE.
- IDLE: ready=1. A rising edge with start=1 (edge E0):
  - latches a, b, c_zero into internal registers
  - clears the chunk index and partial result
  - moves to ADD
- ADD: ready=0. On edges E1..EN, the slice adds latched chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) plus the running carry. It writes that chunk of the partial result, registers the carry, and increments k.
- Final ADD edge EN:
  - sum <= full partial result
  - c_out <= final carry
  - ovf computed as defined
  - done <= 1
  - state -> DONE
- DONE: done=1 for exactly this one cycle, ready=0. The next edge EN+1 returns to IDLE with done=0 and ready=1.
- Latency: done is high in the cycle after EN, i.e. N edges after the accepting edge. Minimum spacing between accepted starts is N+2 edges.
- start while ready=0 (ADD or DONE) is ignored, not queued. Changes to a/b/c_zero after E0 do not affect the operation in flight.
- sum/c_out/ovf change only on edge EN. Otherwise they hold the last result, including across ignored starts.
- Arithmetic is modulo 2^WIDTH. c_out is the true carry; there is no saturation.
- CHUNK=WIDTH is legal: N=1, a single ADD cycle.
- A WIDTH%CHUNK != 0 configuration is rejected at elaboration with $fatal.

Optional Feature:
Macro SUBTRACT_EN.
- Defined: adds input port sub (1 bit), sampled with the operands on E0. When sub=1, the latched B is ~b and the initial carry is forced to 1; c_zero is ignored. The result is a-b mod 2^WIDTH, and c_out=1 means no borrow. ovf follows the same MSB-carry rule, giving signed subtraction overflow. When sub=0, behaviour is identical to the undefined build.
- Undefined: no sub port; the block is add-only as described above.

Test Plan:
WIDTH=16, CHUNK=4 unless stated.
1. Basic add: a=0x0001, b=0x0002, c_zero=0, one-cycle start -> ready drops next cycle; done high exactly 4 edges after the accepting edge; sum=0x0003, c_out=0, ovf=0; ready=1 one cycle later.
2. Full carry ripple: a=0xFFFF, b=0x0001, c_zero=0 -> sum=0x0000, c_out=1, ovf=0. Then a=0x0000, b=0x0000, c_zero=1 -> sum=0x0001, c_out=0.
3. Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
4. Busy handling: start a=0x0005, b=0x0005; pulse start with a=0x1111, b=0x2222 during ADD and during DONE -> exactly one done pulse; sum=0x000A; the ignored requests never produce a done.
5. Reset mid-op: start a=0x00FF, b=0x0001; assert rst asynchronously after 2 ADD edges -> sum=0, c_out=0, done=0, ready=1 immediately. After release, start a=0x0006, b=0x0007 -> sum=0x000D.
6. Parameter sweep and option: CHUNK=16 and CHUNK=1 with a=0xABCD, b=0x1234 -> sum=0xBE01, done latency 1 and 16 edges. With SUBTRACT_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0, ovf=0.

Source files
------------

// File: rtl/multicycle_ripple_adder_if.sv
// Operand/result handshake bundle for multicycle_ripple_adder.
// With SUBTRACT_EN defined the bundle also carries the sub request bit.
interface multicycle_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_zero;
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

`ifdef SUBTRACT_EN
  modport master (output start, a, b, c_zero, sub, input ready, done, sum, c_out, ovf);
  modport slave  (input start, a, b, c_zero, sub, output ready, done, sum, c_out, ovf);
`else
  modport master (output start, a, b, c_zero, input ready, done, sum, c_out, ovf);
  modport slave  (input start, a, b, c_zero, output ready, done, sum, c_out, ovf);
`endif
endinterface

// File: rtl/multicycle_ripple_adder.sv
// Sequential ripple adder: one CHUNK-wide slice reused over WIDTH/CHUNK cycles.
// Optional SUBTRACT_EN macro adds a sub request (a - b, c_out=1 means no borrow).
module multicycle_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_ripple_adder_if.slave bus
);

  localparam int N    = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_cfg_check
    $fatal(1, "multicycle_ripple_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, sum_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, c_out_q, ovf_q, done_q, ready_q;

  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] part_d;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             msb_cin;

  // Operands shift down so the slice always sees bits [CHUNK-1:0]; each result
  // chunk enters at the top of part_q and lands in place after N cycles.
  always_comb begin
    slice   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    part_d  = (part_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice[CHUNK-1];
`ifdef SUBTRACT_EN
    b_in    = bus.sub ? ~bus.b : bus.b;
    cin_in  = bus.sub ? 1'b1 : bus.c_zero;
`else
    b_in    = bus.b;
    cin_in  = bus.c_zero;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= b_in;
            carry_q <= cin_in;
            idx_q   <= '0;
            part_q  <= '0;
            ready_q <= 1'b0;
            state_q <= ADD;
          end
        end
        ADD: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= slice[CHUNK];
          part_q  <= part_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            sum_q   <= part_d;
            c_out_q <= slice[CHUNK];
            ovf_q   <= slice[CHUNK] ^ msb_cin;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_multicycle_ripple_adder.sv
// Self-checking bench for multicycle_ripple_adder (CHUNK 4, 16 and 1 instances).
// Expected results come from plain integer arithmetic on the operands.
module tb_multicycle_ripple_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ripple_adder_if #(.WIDTH(16)) bus0  ();
  multicycle_ripple_adder_if #(.WIDTH(16)) bus16 ();
  multicycle_ripple_adder_if #(.WIDTH(16)) bus1  ();

  multicycle_ripple_adder #(.WIDTH(16), .CHUNK(4))  u_c4  (.clk(clk), .rst(rst), .bus(bus0));
  multicycle_ripple_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (.clk(clk), .rst(rst), .bus(bus16));
  multicycle_ripple_adder #(.WIDTH(16), .CHUNK(1))  u_c1  (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;
  logic [15:0] prev_sum = '0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        c;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic sub, output logic [15:0] s, output logic c,
                                output logic ovf);
    int signed   sa, sb, r;
    int unsigned u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      s = a - b;
      c = (a >= b);
      r = sa - sb;
    end else begin
      u = 32'(a) + 32'(b) + 32'(cin);
      s = u[15:0];
      c = u[16];
      r = sa + sb + int'(cin);
    end
    ovf = (r > 32767) || (r < -32768);
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub_v, input string tag);
    logic [15:0] es;
    logic        ec, eo;
    int          lat;
    model(a, b, cin, sub_v, es, ec, eo);
    @(negedge clk);
    bus0.start  = 1'b1;
    bus0.a      = a;
    bus0.b      = b;
    bus0.c_zero = cin;
`ifdef SUBTRACT_EN
    bus0.sub    = sub_v;
`endif
    @(negedge clk);
    bus0.start = 1'b0;
    bus0.a     = ~a;
    bus0.b     = ~b;
    check({tag, " ready_low"}, 32'(bus0.ready), 32'd0);
    check({tag, " sum_hold"}, 32'(bus0.sum), 32'(prev_sum));
    lat = 0;
    while (!bus0.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(bus0.sum), 32'(es));
    check({tag, " c_out"}, 32'(bus0.c_out), 32'(ec));
    check({tag, " ovf"}, 32'(bus0.ovf), 32'(eo));
    @(negedge clk);
    check({tag, " ready_back"}, 32'(bus0.ready), 32'd1);
    check({tag, " done_pulse"}, 32'(bus0.done), 32'd0);
    prev_sum = es;
  endtask

  vec_t vecs[8];

  initial begin
    int ndone;
    int lat, l16, l1;
    logic [15:0] s16, s1;
    logic        c16, c1;
    logic        rsub;

    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1;
    bus0.start = 1'b0;  bus0.a = '0;  bus0.b = '0;  bus0.c_zero = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_zero = 1'b0;
    bus1.start = 1'b0;  bus1.a = '0;  bus1.b = '0;  bus1.c_zero = 1'b0;
`ifdef SUBTRACT_EN
    bus0.sub = 1'b0; bus16.sub = 1'b0; bus1.sub = 1'b0;
`endif
    #3;
    check("reset ready", 32'(bus0.ready), 32'd1);
    check("reset done", 32'(bus0.done), 32'd0);
    check("reset sum", 32'(bus0.sum), 32'd0);
    check("reset c_out", 32'(bus0.c_out), 32'd0);
    check("reset ovf", 32'(bus0.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: hand-derived expectations.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ms;
      logic        mc, mo;
      model(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, ms, mc, mo);
      check($sformatf("table%0d model_sum", i), 32'(ms), 32'(vecs[i].sum));
      check($sformatf("table%0d model_c", i), 32'(mc), 32'(vecs[i].c));
      check($sformatf("table%0d model_ovf", i), 32'(mo), 32'(vecs[i].ovf));
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, $sformatf("table%0d", i));
    end

    // Busy handling: requests during ADD and DONE are dropped.
    @(negedge clk);
    bus0.start = 1'b1; bus0.a = 16'h0005; bus0.b = 16'h0005; bus0.c_zero = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        ndone++;
        check("busy sum", 32'(bus0.sum), 32'h000A);
      end
      bus0.a = 16'h1111;
      bus0.b = 16'h2222;
      bus0.start = (i == 1) || bus0.done;
    end
    bus0.start = 1'b0;
    check("busy done_count", 32'(ndone), 32'd1);
    check("busy sum_after", 32'(bus0.sum), 32'h000A);
    check("busy ready", 32'(bus0.ready), 32'd1);
    prev_sum = 16'h000A;

    // Reset mid-operation.
    @(negedge clk);
    bus0.start = 1'b1; bus0.a = 16'h00FF; bus0.b = 16'h0001;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst sum", 32'(bus0.sum), 32'd0);
    check("midrst c_out", 32'(bus0.c_out), 32'd0);
    check("midrst done", 32'(bus0.done), 32'd0);
    check("midrst ready", 32'(bus0.ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;
    run_op(16'h0006, 16'h0007, 1'b0, 1'b0, "after_rst");
    check("after_rst no_stale_done", 32'(bus0.done), 32'd0);

`ifdef SUBTRACT_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_5_7");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, "sub_ovf");
`endif

    // Randomised operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      rsub = 1'b0;
`ifdef SUBTRACT_EN
      rsub = 1'($urandom_range(0, 1));
`endif
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), rsub,
             $sformatf("rand%0d", i));
    end

    // CHUNK=16 and CHUNK=1 instances started together.
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = 16'hABCD; bus16.b = 16'h1234;
    bus1.start  = 1'b1; bus1.a  = 16'hABCD; bus1.b  = 16'h1234;
    lat = 0; l16 = -1; l1 = -1;
    s16 = '0; s1 = '0; c16 = 1'b1; c1 = 1'b1;
    repeat (40) begin
      @(negedge clk);
      bus16.start = 1'b0;
      bus1.start  = 1'b0;
      if (bus16.done && l16 < 0) begin l16 = lat; s16 = bus16.sum; c16 = bus16.c_out; end
      if (bus1.done && l1 < 0)   begin l1 = lat;  s1 = bus1.sum;   c1 = bus1.c_out;   end
      lat++;
    end
    check("chunk16 latency", 32'(l16), 32'd1);
    check("chunk16 sum", 32'(s16), 32'hBE01);
    check("chunk16 c_out", 32'(c16), 32'd0);
    check("chunk1 latency", 32'(l1), 32'd16);
    check("chunk1 sum", 32'(s1), 32'hBE01);
    check("chunk1 c_out", 32'(c1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
